// File: rtl/pa_f_spsram_lane_init.sv
// Parametrised single-port SRAM with lane write enables, a hardware clear
// engine and an optional read-data output register.
module pa_f_spsram_lane_init #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           LANE_NUM   = 4,
  parameter int unsigned           LANE_WIDTH = 1,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [LANE_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                           CLK,
  input  logic                           cpurst_b,
  input  logic [ADDR_WIDTH-1:0]          A,
  input  logic                           CEN,
  input  logic                           GWEN,
  input  logic [LANE_NUM-1:0]            WEN,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] D,
  input  logic                           INIT_REQ,
  output logic [LANE_NUM*LANE_WIDTH-1:0] Q,
  output logic                           INIT_BUSY,
  output logic                           ACC_ERR
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned DW    = LANE_NUM * LANE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  clr_we_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [DW-1:0]         q_q;

  logic [DW-1:0] mem [DEPTH];

  // Clear engine sequencing and access qualification
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    wr_c     = 1'b0;
    rd_c     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we_c = 1'b1;
        err_d    = ~CEN;
        cnt_d    = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        wr_c = ~CEN & ~GWEN;
        rd_c = ~CEN & GWEN;
        if (INIT_REQ) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array port: clear writes win; user writes are masked per lane
  always_ff @(posedge CLK) begin
    if (clr_we_c) begin
      mem[cnt_q] <= {LANE_NUM{INIT_VAL}};
    end else if (wr_c) begin
      for (int i = 0; i < int'(LANE_NUM); i++) begin
        if (!WEN[i]) begin
          mem[A][i*LANE_WIDTH +: LANE_WIDTH] <= D[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_q_direct
      always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
          q_q <= '0;
        end else if (rd_c) begin
          q_q <= mem[A];
        end
      end
    end else begin : g_q_piped
      logic [DW-1:0] rd_q;
      logic          rd_vld_q;

      // Second stage only advances behind a real read so Q holds when idle
      always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
          rd_q     <= '0;
          rd_vld_q <= 1'b0;
          q_q      <= '0;
        end else begin
          rd_vld_q <= rd_c;
          if (rd_c) begin
            rd_q <= mem[A];
          end
          if (rd_vld_q) begin
            q_q <= rd_q;
          end
        end
      end
    end
  endgenerate

  assign Q         = q_q;
  assign INIT_BUSY = busy_q;
  assign ACC_ERR   = err_q;

endmodule

// File: tb/tb_pa_f_spsram_lane_init.sv
// Self-checking bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus
// and are compared every cycle against a behavioural memory model.
module tb_pa_f_spsram_lane_init;

  localparam int unsigned DEPTH = 1024;

  logic       clk;
  logic       rst_n;
  logic [9:0] a;
  logic       cen;
  logic       gwen;
  logic [3:0] wen;
  logic [3:0] d;
  logic       init_req;
  logic [3:0] q0, q1;
  logic       busy0, busy1;
  logic       err0, err1;

  int n_chk;
  int n_fail;

  // Reference model state
  logic [3:0] mem_m [DEPTH];
  logic       busy_m;
  int         clr_idx;
  logic       err_m;
  logic [3:0] q0_m, q1_m;
  logic       pend_vld;
  logic [3:0] pend_d;

  pa_f_spsram_lane_init #(.OUT_REG(0)) dut0 (
    .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .D(d), .INIT_REQ(init_req), .Q(q0), .INIT_BUSY(busy0), .ACC_ERR(err0)
  );

  pa_f_spsram_lane_init #(.OUT_REG(1)) dut1 (
    .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .D(d), .INIT_REQ(init_req), .Q(q1), .INIT_BUSY(busy1), .ACC_ERR(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy_m   = 1'b1;
    clr_idx  = 0;
    err_m    = 1'b0;
    q0_m     = '0;
    q1_m     = '0;
    pend_vld = 1'b0;
    pend_d   = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge
  task automatic model_edge();
    logic       rd;
    logic [3:0] rdat;
    rd    = 1'b0;
    rdat  = '0;
    err_m = busy_m && !cen;
    if (busy_m) begin
      mem_m[clr_idx] = 4'h0;
      clr_idx++;
      if (clr_idx == DEPTH) busy_m = 1'b0;
    end else begin
      if (!cen) begin
        if (!gwen) begin
          for (int i = 0; i < 4; i++)
            if (!wen[i]) mem_m[a][i] = d[i];
        end else begin
          rd   = 1'b1;
          rdat = mem_m[a];
        end
      end
      if (init_req) begin
        busy_m  = 1'b1;
        clr_idx = 0;
      end
    end
    if (rd) q0_m = rdat;
    if (pend_vld) q1_m = pend_d;
    pend_vld = rd;
    pend_d   = rdat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("busy0", 32'(busy0), 32'(busy_m));
    chk("busy1", 32'(busy1), 32'(busy_m));
    chk("err0", 32'(err0), 32'(err_m));
    chk("err1", 32'(err1), 32'(err_m));
    chk("q0", 32'(q0), 32'(q_m_sel(0)));
    chk("q1", 32'(q1), 32'(q_m_sel(1)));
  endtask

  function automatic logic [3:0] q_m_sel(input int which);
    return (which == 0) ? q0_m : q1_m;
  endfunction

  task automatic idle();
    cen = 1'b1; gwen = 1'b1; wen = 4'hF; init_req = 1'b0;
    a = 10'($urandom); d = 4'($urandom);
  endtask

  task automatic acc(input logic wr, input logic [9:0] ad, input logic [3:0] dat, input logic [3:0] we);
    cen = 1'b0; gwen = ~wr; a = ad; d = dat; wen = we; init_req = 1'b0;
    step();
  endtask

  // Steps while the DUT reports busy; optional INIT_REQ and access pulses inside
  task automatic run_clear(input int req_at, input int acc_at, output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 2000) begin
      idle();
      init_req = (n == req_at);
      if (n == acc_at) begin
        cen = 1'b0; gwen = 1'b0; a = 10'h010; d = 4'hA; wen = 4'h0;
      end
      step();
      n++;
      if (n - 1 == acc_at) chk("acc_err_pulse", 32'(err0), 32'd1);
    end
    idle();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_err", 32'(err0), 32'd0);
    @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    model_reset();
    #12;
    chk("por_q0", 32'(q0), 32'd0);
    chk("por_q1", 32'(q1), 32'd0);
    chk("por_busy", 32'(busy1), 32'd1);
    chk("por_err", 32'(err1), 32'd0);
    @(posedge clk);
    #4 rst_n = 1'b1;

    // Power-up clear with an offending write at clear cycle 100
    run_clear(-1, 100, n);
    chk("clear_len", 32'(n), 32'd1024);

    acc(1'b0, 10'h3FF, 4'h0, 4'hF);
    chk("rd_3ff", 32'(q0), 32'h0);
    acc(1'b0, 10'h010, 4'h0, 4'hF);
    chk("rd_010", 32'(q0), 32'h0);

    // Lane-masked write, Q must hold during the write
    acc(1'b0, 10'h3FF, 4'h0, 4'hF);
    acc(1'b0, 10'h000, 4'h0, 4'hF);
    acc(1'b1, 10'h005, 4'hF, 4'b1010);
    chk("wr_hold", 32'(q0), 32'h0);
    acc(1'b0, 10'h005, 4'h0, 4'hF);
    chk("rd_005", 32'(q0), 32'h5);
    acc(1'b1, 10'h005, 4'h3, 4'hF);
    chk("no_lane_err", 32'(err0), 32'd0);

    // Pipelined reads through the output-register instance
    acc(1'b1, 10'h001, 4'h1, 4'h0);
    acc(1'b1, 10'h002, 4'h2, 4'h0);
    acc(1'b1, 10'h003, 4'h3, 4'h0);
    acc(1'b0, 10'h001, 4'h0, 4'hF);
    acc(1'b0, 10'h002, 4'h0, 4'hF);
    chk("pipe_1", 32'(q1), 32'h1);
    acc(1'b0, 10'h003, 4'h0, 4'hF);
    chk("pipe_2", 32'(q1), 32'h2);
    idle(); step();
    chk("pipe_3", 32'(q1), 32'h3);
    idle(); step(); step(); step();
    chk("pipe_hold", 32'(q1), 32'h3);
    chk("direct_hold", 32'(q0), 32'h3);

    // Random traffic over a small hot window plus the full range
    for (int i = 0; i < 600; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        cen  = 1'b0;
        gwen = 1'($urandom);
        a    = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        d    = 4'($urandom);
        wen  = 4'($urandom);
      end
      step();
    end

    // Fill with 7, request a clear alongside a read, re-request mid-clear
    for (int i = 0; i < int'(DEPTH); i++) acc(1'b1, 10'(i), 4'h7, 4'h0);
    acc(1'b0, 10'h200, 4'h0, 4'hF);
    cen = 1'b0; gwen = 1'b1; a = 10'h201; init_req = 1'b1;
    step();
    chk("req_rd", 32'(q0), 32'h7);
    chk("req_busy", 32'(busy0), 32'd1);
    run_clear(300, -1, n);
    chk("reclear_len", 32'(n), 32'd1024);
    for (int i = 0; i < int'(DEPTH); i++) acc(1'b0, 10'(i), 4'h0, 4'hF);
    idle(); step(); step();
    chk("last_rd0", 32'(q0), 32'h0);
    chk("last_rd1", 32'(q1), 32'h0);

    // Reset at clear cycle 500 restarts the full clear
    acc(1'b1, 10'h009, 4'hF, 4'h0);
    acc(1'b0, 10'h009, 4'h0, 4'hF);
    idle(); step();
    chk("pre_rst_q", 32'(q1), 32'hF);
    init_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 500; i++) step();
    async_reset();
    run_clear(-1, -1, n);
    chk("rst_clear_len", 32'(n), 32'd1024);
    acc(1'b0, 10'h009, 4'h0, 4'hF);
    chk("post_rst_rd", 32'(q0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
